// File: rtl/csr_exec_unit.sv
// Zicsr execution unit: sequences read -> modify -> write on the CSR file ports
// and returns the previous CSR value for rd, flagging illegal encodings.
module csr_exec_unit #(
    parameter int XLEN     = 32,
    parameter int CSR_AW   = 12,
    parameter bit RO_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [CSR_AW-1:0] req_csr_addr,
    input  logic [4:0]        req_rs1_idx,
    input  logic [XLEN-1:0]   req_rs1_data,
    input  logic [4:0]        req_rd,
    output logic              csr_ren,
    output logic [CSR_AW-1:0] csr_raddr,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              csr_wen,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              inst_done,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_rd_we,
    output logic [4:0]        resp_rd,
    output logic [XLEN-1:0]   resp_rd_data,
    output logic              resp_illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    // funct3[1:0]: 01 write, 10 set, 11 clear; 00 never reaches WRITE
    function automatic logic [XLEN-1:0] csr_modify(
        input logic [1:0]      op,
        input logic [XLEN-1:0] old_val,
        input logic [XLEN-1:0] operand
    );
        logic [XLEN-1:0] result;
        case (op)
            2'b10:   result = old_val | operand;
            2'b11:   result = old_val & ~operand;
            default: result = operand;
        endcase
        return result;
    endfunction

    state_t            state_r, state_s;
    logic [1:0]        op_r, op_s;
    logic [CSR_AW-1:0] addr_r, addr_s;
    logic [4:0]        rd_r, rd_s;
    logic [XLEN-1:0]   operand_r, operand_s;
    logic [XLEN-1:0]   old_r, old_s;
    logic              illegal_r, illegal_s;
    logic              do_write_r, do_write_s;
    logic              do_read_r, do_read_s;

    logic              req_ready_r;
    logic              csr_ren_r;
    logic              csr_wen_r;
    logic [XLEN-1:0]   csr_wdata_r, csr_wdata_s;
    logic              resp_valid_r;
    logic              resp_rd_we_r, resp_rd_we_s;
    logic [XLEN-1:0]   resp_rd_data_r, resp_rd_data_s;
    logic              resp_illegal_r, resp_illegal_s;

    logic              dec_rw_s;
    logic              dec_do_write_s;
    logic              dec_do_read_s;
    logic              dec_illegal_s;
    logic [XLEN-1:0]   dec_operand_s;

    // Decode of the presented request, used only at accept
    always_comb begin
        dec_rw_s       = (req_funct3[1:0] == 2'b01);
        dec_do_write_s = dec_rw_s || (req_rs1_idx != 5'd0);
        dec_do_read_s  = !(dec_rw_s && (req_rd == 5'd0));
        dec_illegal_s  = (req_funct3[1:0] == 2'b00) ||
                         (RO_CHECK && (req_csr_addr[CSR_AW-1:CSR_AW-2] == 2'b11) && dec_do_write_s);
        if (req_funct3[2]) begin
            dec_operand_s = {{(XLEN-5){1'b0}}, req_rs1_idx};
        end else begin
            dec_operand_s = req_rs1_data;
        end
    end

    // Next-state and latched-operand logic
    always_comb begin
        state_s    = state_r;
        op_s       = op_r;
        addr_s     = addr_r;
        rd_s       = rd_r;
        operand_s  = operand_r;
        old_s      = old_r;
        illegal_s  = illegal_r;
        do_write_s = do_write_r;
        do_read_s  = do_read_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    op_s       = req_funct3[1:0];
                    addr_s     = req_csr_addr;
                    rd_s       = req_rd;
                    operand_s  = dec_operand_s;
                    old_s      = {XLEN{1'b0}};
                    illegal_s  = dec_illegal_s;
                    do_write_s = dec_do_write_s;
                    do_read_s  = dec_do_read_s;
                    if (dec_illegal_s) begin
                        state_s = RESP;
                    end else if (dec_do_read_s) begin
                        state_s = READ;
                    end else begin
                        state_s = WRITE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                old_s = csr_rdata;
                if (do_write_r) begin
                    state_s = WRITE;
                end else begin
                    state_s = RESP;
                end
            end
            WRITE: begin
                state_s = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output values for the upcoming state so every output leaves a flop
    always_comb begin
        csr_wdata_s    = csr_wdata_r;
        resp_rd_we_s   = 1'b0;
        resp_rd_data_s = old_s;
        resp_illegal_s = 1'b0;
        if (state_s == WRITE) begin
            csr_wdata_s = csr_modify(op_s, old_s, operand_s);
        end else begin
            csr_wdata_s = csr_wdata_r;
        end
        if (state_s == RESP) begin
            resp_rd_we_s   = !illegal_s && do_read_s && (rd_s != 5'd0);
            resp_illegal_s = illegal_s;
        end else begin
            resp_rd_we_s   = 1'b0;
            resp_illegal_s = 1'b0;
        end
    end

    // State, operand and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            op_r           <= 2'b00;
            addr_r         <= {CSR_AW{1'b0}};
            rd_r           <= 5'd0;
            operand_r      <= {XLEN{1'b0}};
            old_r          <= {XLEN{1'b0}};
            illegal_r      <= 1'b0;
            do_write_r     <= 1'b0;
            do_read_r      <= 1'b0;
            req_ready_r    <= 1'b1;
            csr_ren_r      <= 1'b0;
            csr_wen_r      <= 1'b0;
            csr_wdata_r    <= {XLEN{1'b0}};
            resp_valid_r   <= 1'b0;
            resp_rd_we_r   <= 1'b0;
            resp_rd_data_r <= {XLEN{1'b0}};
            resp_illegal_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            op_r           <= op_s;
            addr_r         <= addr_s;
            rd_r           <= rd_s;
            operand_r      <= operand_s;
            old_r          <= old_s;
            illegal_r      <= illegal_s;
            do_write_r     <= do_write_s;
            do_read_r      <= do_read_s;
            req_ready_r    <= (state_s == IDLE);
            csr_ren_r      <= (state_s == READ);
            csr_wen_r      <= (state_s == WRITE);
            csr_wdata_r    <= csr_wdata_s;
            resp_valid_r   <= (state_s == RESP);
            resp_rd_we_r   <= resp_rd_we_s;
            resp_rd_data_r <= resp_rd_data_s;
            resp_illegal_r <= resp_illegal_s;
        end
    end

    assign req_ready    = req_ready_r;
    assign csr_ren      = csr_ren_r;
    assign csr_raddr    = addr_r;
    assign csr_wen      = csr_wen_r;
    assign csr_waddr    = addr_r;
    assign csr_wdata    = csr_wdata_r;
    assign resp_valid   = resp_valid_r;
    assign resp_rd_we   = resp_rd_we_r;
    assign resp_rd      = rd_r;
    assign resp_rd_data = resp_rd_data_r;
    assign resp_illegal = resp_illegal_r;
    // Retire pulse coincides with the response handshake of a legal instruction
    assign inst_done    = resp_valid_r && resp_ready && !resp_illegal_r;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit: stimulus pushes expected CSR port activity and
// responses, a negedge monitor pops and compares them.
module tb_csr_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr_addr;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_rd;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        inst_done;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_rd_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_rd_data;
    logic        resp_illegal;
    logic [31:0] csr_val;

    typedef struct packed { logic we; logic [4:0] rd; logic [31:0] data; logic ill; } resp_t;
    typedef struct packed { logic [11:0] addr; logic [31:0] data; } wr_t;

    resp_t       resp_q[$];
    wr_t         wr_q[$];
    logic [11:0] rd_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    assign csr_rdata = csr_val;

    csr_exec_unit #(.XLEN(32), .CSR_AW(12), .RO_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_csr_addr(req_csr_addr), .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
        .req_rd(req_rd),
        .csr_ren(csr_ren), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .inst_done(inst_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd_we(resp_rd_we),
        .resp_rd(resp_rd), .resp_rd_data(resp_rd_data), .resp_illegal(resp_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h expected none", name, act);
    endtask

    // Monitor: CSR port activity and response handshakes against the scoreboard
    always @(negedge clk) begin
        resp_t       e;
        wr_t         w;
        logic [11:0] a;
        if (rst_n) begin
            if (csr_ren && csr_wen) flag("ren_wen_together", 32'(csr_raddr));
            if (csr_ren) begin
                if (rd_q.size() == 0) flag("unexpected_read", 32'(csr_raddr));
                else begin
                    a = rd_q.pop_front();
                    check("read_addr", 32'(csr_raddr), 32'(a));
                end
            end
            if (csr_wen) begin
                if (wr_q.size() == 0) flag("unexpected_write", csr_wdata);
                else begin
                    w = wr_q.pop_front();
                    check("write_addr", 32'(csr_waddr), 32'(w.addr));
                    check("write_data", csr_wdata, w.data);
                end
            end
            if (resp_valid && resp_ready) begin
                if (resp_q.size() == 0) flag("unexpected_resp", resp_rd_data);
                else begin
                    e = resp_q.pop_front();
                    check("resp_rd_we", 32'(resp_rd_we), 32'(e.we));
                    check("resp_rd", 32'(resp_rd), 32'(e.rd));
                    check("resp_illegal", 32'(resp_illegal), 32'(e.ill));
                    if (!e.ill) check("resp_rd_data", resp_rd_data, e.data);
                    check("inst_done", 32'(inst_done), 32'(!e.ill));
                end
            end else if (inst_done) begin
                flag("inst_done_no_handshake", 32'(inst_done));
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                         input logic [31:0] rs1d, input logic [4:0] rd, input logic [31:0] cval,
                         input bit exp_rd, input bit exp_wr, input logic [31:0] exp_wd,
                         input bit exp_we, input logic [31:0] exp_rdd, input bit exp_ill,
                         input int exp_lat, input int hold);
        resp_t r;
        wr_t   w;
        int    lat;
        bit    seen;
        if (exp_rd) rd_q.push_back(addr);
        if (exp_wr) begin
            w.addr = addr;
            w.data = exp_wd;
            wr_q.push_back(w);
        end
        r.we = exp_we; r.rd = rd; r.data = exp_rdd; r.ill = exp_ill;
        resp_q.push_back(r);
        @(negedge clk);
        csr_val = cval;
        req_funct3 = f3; req_csr_addr = addr; req_rs1_idx = idx;
        req_rs1_data = rs1d; req_rd = rd; req_valid = 1'b1;
        if (hold > 0) resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("latency", seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                if (i > 0) @(negedge clk);
                check("hold_resp_valid", 32'(resp_valid), 32'd1);
                check("hold_req_ready", 32'(req_ready), 32'd0);
                check("hold_rd_data", resp_rd_data, exp_rdd);
                check("hold_rd_we", 32'(resp_rd_we), 32'(exp_we));
                if (i == 0) begin
                    req_funct3 = 3'b011; req_csr_addr = 12'h123; req_rs1_idx = 5'd9;
                    req_rs1_data = 32'hFFFF_FFFF; req_rd = 5'd2; req_valid = 1'b1;
                end
            end
            @(negedge clk);
            req_valid = 1'b0;
            @(posedge clk);
            #1 resp_ready = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("return_idle", 32'(seen), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_funct3 = 3'b000; req_csr_addr = 12'h000;
        req_rs1_idx = 5'd0; req_rs1_data = 32'h0; req_rd = 5'd0; resp_ready = 1'b1;
        csr_val = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_csr_ren", 32'(csr_ren), 32'd0);
        check("rst_csr_wen", 32'(csr_wen), 32'd0);
        check("rst_inst_done", 32'(inst_done), 32'd0);
        check("rst_rd_data", resp_rd_data, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // CSRRS x5, cycle, x0: read only
        issue(3'b010, 12'hC00, 5'd0, 32'hDEAD_BEEF, 5'd5, 32'h0000_1234,
              1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_1234, 1'b0, 2, 0);
        // CSRRC a0, 0x340, rs1=0x0F
        issue(3'b011, 12'h340, 5'd11, 32'h0000_000F, 5'd10, 32'h0000_00FF,
              1'b1, 1'b1, 32'h0000_00F0, 1'b1, 32'h0000_00FF, 1'b0, 3, 0);
        // CSRRW x0, 0x340, 0xA5: write only
        issue(3'b001, 12'h340, 5'd6, 32'h0000_00A5, 5'd0, 32'h0000_0077,
              1'b0, 1'b1, 32'h0000_00A5, 1'b0, 32'h0, 1'b0, 2, 0);
        // CSRRWI to read-only 0xC02, then reserved funct3 100
        issue(3'b101, 12'hC02, 5'd3, 32'h0, 5'd7, 32'h0,
              1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1, 0);
        issue(3'b100, 12'hC02, 5'd3, 32'h0, 5'd7, 32'h0,
              1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1, 0);
        // CSRRW with register operand to read-only space
        issue(3'b001, 12'hC00, 5'd4, 32'h1, 5'd2, 32'h0,
              1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1, 0);
        // CSRRCI zimm=0 on read-only CSR: legal pure read
        issue(3'b111, 12'hC01, 5'd0, 32'hFFFF_FFFF, 5'd3, 32'hCAFE_0001,
              1'b1, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001, 1'b0, 2, 0);
        // CSRRSI rd=1, 0x7C0, zimm=0x1F
        issue(3'b110, 12'h7C0, 5'h1F, 32'h0, 5'd1, 32'h8000_0000,
              1'b1, 1'b1, 32'h8000_001F, 1'b1, 32'h8000_0000, 1'b0, 3, 0);
        // CSRRWI x0, 0x305, zimm=0: write-only of zero
        issue(3'b101, 12'h305, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h1234_5678,
              1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 2, 0);
        // CSRRW with writeback stalled for 5 cycles
        issue(3'b001, 12'h341, 5'd8, 32'h1111_2222, 5'd4, 32'h5555_AAAA,
              1'b1, 1'b1, 32'h1111_2222, 1'b1, 32'h5555_AAAA, 1'b0, 3, 5);

        // Reset during WRITE drops the write and the response
        @(negedge clk);
        req_funct3 = 3'b001; req_csr_addr = 12'h300; req_rs1_idx = 5'd6;
        req_rs1_data = 32'h0000_0042; req_rd = 5'd0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("t1_wen_before_reset", 32'(csr_wen), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t1_csr_wen", 32'(csr_wen), 32'd0);
        check("t1_req_ready", 32'(req_ready), 32'd1);
        check("t1_resp_valid", 32'(resp_valid), 32'd0);
        check("t1_inst_done", 32'(inst_done), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Unit still works after the interrupted operation
        issue(3'b010, 12'h300, 5'd2, 32'h0000_0F00, 5'd9, 32'h0000_00F0,
              1'b1, 1'b1, 32'h0000_0FF0, 1'b1, 32'h0000_00F0, 1'b0, 3, 0);

        repeat (3) @(negedge clk);
        check("resp_q_empty", 32'(resp_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
